// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed byte image into instruction memory and
// holds the CPU in reset until a load completes with a matching checksum.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [23:0]       sr_q, sr_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       len_full;
    logic              accept;

    // Valid/ready: a byte moves on a rising edge where in_valid && in_ready;
    // ready depends only on state (and is forced low while rst is held).
    assign in_ready = !rst && ((state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                               (state_q == S_DATA)   || (state_q == S_CSUM));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        sr_d     = sr_q;
        bcnt_d   = bcnt_q;
        wcnt_d   = wcnt_q;
        csum_d   = csum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        len_full = {len_q[15:8], in_data};
        case (state_q)
            S_LEN_HI: if (accept) begin
                len_d   = {in_data, 8'd0};
                state_d = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                len_d = len_full;
                if (32'(len_full) > DEPTH)  state_d = S_ERR;
                else if (len_full == 16'd0) state_d = S_CSUM;
                else                        state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                sr_d   = {sr_q[15:0], in_data};
                csum_d = csum_q ^ in_data;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    we_d    = 1'b1;
                    wdata_d = {sr_q, in_data};
                    addr_d  = wcnt_q[ADDR_W-1:0];
                    wcnt_d  = wcnt_q + {{ADDR_W{1'b0}}, 1'b1};
                    if ((32'(wcnt_q) + 32'd1) == 32'(len_q)) state_d = S_CSUM;
                end
            end
            S_CSUM: if (accept) begin
                state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: if (reload) begin
                state_d = S_LEN_HI;
                len_d   = '0;
                sr_d    = '0;
                bcnt_d  = '0;
                wcnt_d  = '0;
                csum_d  = '0;
            end
            default: state_d = S_LEN_HI;
        endcase
        // Status flags are registered from the next state so they settle one
        // edge after the deciding byte and never glitch.
        cpu_rst_d = (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LEN_HI;
            len_q     <= '0;
            sr_q      <= '0;
            bcnt_q    <= '0;
            wcnt_q    <= '0;
            csum_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            sr_q      <= sr_d;
            bcnt_q    <= bcnt_d;
            wcnt_q    <= wcnt_d;
            csum_q    <= csum_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream driver, write scoreboard keyed on
// expected {addr, data}, and status checks after each load.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr_base;
    logic [ADDR_W-1:0]  last_addr = '0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] mon_e;
    logic [31:0]        prog[0:255];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_cnt++;
            last_addr = imem_addr;
            if (exp_q.size() == 0) begin
                chk("spurious_write", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(mon_e[ADDR_W+31:32]));
                chk("wr_data", imem_wdata, mon_e[31:0]);
            end
        end
    end

    // driver tasks (called at a negedge)
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        gap = $urandom_range(0, gap_max);
        repeat (gap) @(negedge clk);
    endtask

    task automatic load(input int n, input int gap_max, input logic [7:0] flip, input int max_bytes);
        logic [7:0]  cs = 8'd0;
        logic [15:0] len = 16'(n);
        logic [7:0]  b;
        int sent = 0;
        send_byte(len[15:8], gap_max);
        send_byte(len[7:0], gap_max);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (sent == max_bytes) return;
                b  = prog[i][31-8*j -: 8];
                cs = cs ^ b;
                if (j == 3) exp_q.push_back({ADDR_W'(i), prog[i]});
                send_byte(b, gap_max);
                sent++;
            end
        end
        send_byte(cs ^ flip, gap_max);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_err", 32'(err), 32'd0);
        chk("reload_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_err"}, 32'(err), 32'(e));
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!d));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // two-word program, good checksum (0x25)
        prog[0] = 32'h24080005; prog[1] = 32'h0000000C;
        wr_base = wr_cnt;
        load(2, 0, 8'h00, 1 << 20);
        chk("good_writes", 32'(wr_cnt - wr_base), 32'd2);
        chk_status("good", 1'b1, 1'b0);

        // same program, checksum 0x26
        do_reload();
        wr_base = wr_cnt;
        load(2, 0, 8'h03, 1 << 20);
        chk("badcs_writes", 32'(wr_cnt - wr_base), 32'd2);
        chk_status("badcs", 1'b0, 1'b1);

        // empty program
        do_reload();
        wr_base = wr_cnt;
        load(0, 0, 8'h00, 1 << 20);
        chk("len0_writes", 32'(wr_cnt - wr_base), 32'd0);
        chk_status("len0", 1'b1, 1'b0);

        // length 257 exceeds a 256-word memory
        do_reload();
        wr_base = wr_cnt;
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        repeat (3) @(negedge clk);
        chk("len257_writes", 32'(wr_cnt - wr_base), 32'd0);
        chk_status("len257", 1'b0, 1'b1);

        // three words with random idle gaps between bytes
        do_reload();
        for (int i = 0; i < 3; i++) prog[i] = $urandom;
        wr_base = wr_cnt;
        load(3, 3, 8'h00, 1 << 20);
        chk("gappy_writes", 32'(wr_cnt - wr_base), 32'd3);
        chk_status("gappy", 1'b1, 1'b0);

        // reset after six data bytes, then a fresh one-word load
        do_reload();
        for (int i = 0; i < 3; i++) prog[i] = $urandom;
        wr_base = wr_cnt;
        load(3, 0, 8'h00, 6);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_writes", 32'(wr_cnt - wr_base), 32'd1);
        chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        prog[0] = 32'hDEADBEEF;
        wr_base = wr_cnt;
        load(1, 0, 8'h00, 1 << 20);
        chk("deadbeef_writes", 32'(wr_cnt - wr_base), 32'd1);
        chk_status("deadbeef", 1'b1, 1'b0);

        // full memory
        do_reload();
        for (int i = 0; i < 256; i++) prog[i] = $urandom;
        wr_base = wr_cnt;
        load(256, 0, 8'h00, 1 << 20);
        chk("full_writes", 32'(wr_cnt - wr_base), 32'd256);
        chk("full_last_addr", 32'(last_addr), 32'd255);
        chk_status("full", 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
